// File: rtl/spi_responder_pkg.sv
// Shared types and constants for the SPI responder.
// Holds the frame state enum, synchronizer depth and the width clamp helper.
package spi_responder_pkg;

    localparam int SYNC_STAGES = 2;
    localparam int MAX_WIDTH   = 32;

    typedef enum logic [1:0] {
        WAIT_CS_HIGH,
        IDLE,
        ACTIVE,
        DRAIN
    } state_t;

    // A width of zero, or one beyond the shift register, selects the full register
    function automatic logic [7:0] clamp_width(input logic [7:0] width, input int max_width);
        if (width == 8'd0 || int'(width) > max_width) begin
            return 8'(max_width);
        end
        return width;
    endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Synchronizes CS/SCLK/MOSI into the CLK domain and flags CS/SCLK edges.
// Levels and edge pulses appear 3 CLK cycles after the pin changes.
module spi_input_sync
    import spi_responder_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_cs,
    input  logic i_sclk,
    input  logic i_mosi,
    output logic o_cs,
    output logic o_mosi,
    output logic o_cs_rise,
    output logic o_cs_fall,
    output logic o_sclk_rise,
    output logic o_sclk_fall
);

    // Bit order in every 3-bit group: {cs, sclk, mosi}
    logic [SYNC_STAGES-1:0][2:0] r_sync;
    logic [2:0]                  r_lvl;
    logic [3:0]                  r_edge;
    logic [2:0]                  w_s;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= '0;
            r_lvl  <= '0;
            r_edge <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], {i_cs, i_sclk, i_mosi}};
            r_lvl  <= w_s;
            r_edge <= {w_s[2] & ~r_lvl[2], ~w_s[2] & r_lvl[2],
                       w_s[1] & ~r_lvl[1], ~w_s[1] & r_lvl[1]};
        end
    end

    assign o_cs        = r_lvl[2];
    assign o_mosi      = r_lvl[0];
    assign o_cs_rise   = r_edge[3];
    assign o_cs_fall   = r_edge[2];
    assign o_sclk_rise = r_edge[1];
    assign o_sclk_fall = r_edge[0];

endmodule

// File: rtl/spi_responder.sv
// SPI target: shifts tx_hold out on MISO and returns the MOSI word on DOUT.
// MISO is 4 CLK after the SCLK pin edge; DOUT_VALID is 5 CLK after the last sample edge.
module spi_responder #(
    parameter int MAX_WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 SPI_CS,
    input  logic                 SPI_SCLK,
    input  logic                 SPI_MOSI,
    output logic                 SPI_MISO,
    output logic                 SPI_MISO_OE,
    input  logic                 CPOL,
    input  logic                 CPHA,
    input  logic [7:0]           MOSI_WIDTH,
    input  logic [7:0]           MISO_WIDTH,
    input  logic [MAX_WIDTH-1:0] TX_DIN,
    input  logic                 TX_WE,
    output logic [MAX_WIDTH-1:0] DOUT,
    output logic                 DOUT_VALID,
    output logic                 ABORT,
    output logic                 BUSY
);
    import spi_responder_pkg::*;

    localparam int IW = $clog2(MAX_WIDTH);

    state_t               r_state, w_state_nxt;
    logic                 w_cs_lvl, w_mosi, w_cs_rise, w_cs_fall, w_sclk_rise, w_sclk_fall;
    logic                 r_cpol, r_cpha;
    logic [7:0]           r_mosi_w, r_miso_w, r_rx_cnt, r_tx_cnt;
    logic [MAX_WIDTH-1:0] r_tx_hold, r_tx_sr, r_rx, r_dout;
    logic                 r_miso, r_oe, r_done_pend, r_dout_valid, r_abort;
    logic                 w_lead, w_trail, w_sample, w_shift;
    logic                 w_start, w_done, w_end, w_abort;
    logic [MAX_WIDTH-1:0] w_rx_shift, w_tx_load;
    logic [7:0]           w_miso_w_in, w_rx_cnt_inc;
    logic [IW-1:0]        w_load_idx, w_tx_idx;

    spi_input_sync u_sync (
        .i_clk       (CLK),
        .i_reset     (RESET),
        .i_cs        (SPI_CS),
        .i_sclk      (SPI_SCLK),
        .i_mosi      (SPI_MOSI),
        .o_cs        (w_cs_lvl),
        .o_mosi      (w_mosi),
        .o_cs_rise   (w_cs_rise),
        .o_cs_fall   (w_cs_fall),
        .o_sclk_rise (w_sclk_rise),
        .o_sclk_fall (w_sclk_fall)
    );

    assign w_lead       = r_cpol ? w_sclk_fall : w_sclk_rise;
    assign w_trail      = r_cpol ? w_sclk_rise : w_sclk_fall;
    assign w_sample     = (r_state == ACTIVE) && (r_cpha ? w_trail : w_lead);
    assign w_shift      = (r_state == ACTIVE || r_state == DRAIN) && (r_cpha ? w_lead : w_trail);
    assign w_rx_cnt_inc = r_rx_cnt + 8'd1;
    assign w_rx_shift   = (r_rx << 1) | MAX_WIDTH'(w_mosi);
    assign w_tx_load    = TX_WE ? TX_DIN : r_tx_hold;
    assign w_miso_w_in  = clamp_width(MISO_WIDTH, MAX_WIDTH);
    assign w_load_idx   = IW'(w_miso_w_in - 8'd1);
    assign w_tx_idx     = IW'(r_miso_w - 8'd1);

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= WAIT_CS_HIGH;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_done      = 1'b0;
        w_end       = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            WAIT_CS_HIGH: if (w_cs_lvl) w_state_nxt = IDLE;
            IDLE: begin
                if (w_cs_fall) begin
                    w_start     = 1'b1;
                    w_state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                // A final sample coinciding with CS rise still completes the word
                if (w_sample && w_rx_cnt_inc == r_mosi_w) begin
                    w_done      = 1'b1;
                    w_state_nxt = DRAIN;
                end
                if (w_cs_rise) begin
                    w_end       = 1'b1;
                    w_abort     = !w_done;
                    w_state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (w_cs_rise) begin
                    w_end       = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = WAIT_CS_HIGH;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cpol       <= 1'b0;
            r_cpha       <= 1'b0;
            r_mosi_w     <= '0;
            r_miso_w     <= '0;
            r_rx_cnt     <= '0;
            r_tx_cnt     <= '0;
            r_tx_hold    <= '0;
            r_tx_sr      <= '0;
            r_rx         <= '0;
            r_dout       <= '0;
            r_miso       <= 1'b0;
            r_oe         <= 1'b0;
            r_done_pend  <= 1'b0;
            r_dout_valid <= 1'b0;
            r_abort      <= 1'b0;
        end else begin
            r_done_pend  <= w_done;
            r_dout_valid <= r_done_pend;
            r_abort      <= w_abort;
            if (TX_WE) r_tx_hold <= TX_DIN;
            if (w_done) r_dout <= w_rx_shift;
            if (w_start) begin
                r_cpol   <= CPOL;
                r_cpha   <= CPHA;
                r_mosi_w <= clamp_width(MOSI_WIDTH, MAX_WIDTH);
                r_miso_w <= w_miso_w_in;
                r_rx     <= '0;
                r_rx_cnt <= '0;
                r_oe     <= 1'b1;
                // CPHA=0 puts the first bit on the line before any SCLK edge
                if (CPHA) begin
                    r_tx_sr  <= w_tx_load;
                    r_tx_cnt <= 8'd0;
                    r_miso   <= 1'b0;
                end else begin
                    r_tx_sr  <= w_tx_load << 1;
                    r_tx_cnt <= 8'd1;
                    r_miso   <= w_tx_load[w_load_idx];
                end
            end else if (w_end) begin
                r_oe   <= 1'b0;
                r_miso <= 1'b0;
            end else begin
                if (w_sample) begin
                    r_rx     <= w_rx_shift;
                    r_rx_cnt <= w_rx_cnt_inc;
                end
                if (w_shift) begin
                    if (r_tx_cnt < r_miso_w) begin
                        r_miso   <= r_tx_sr[w_tx_idx];
                        r_tx_sr  <= r_tx_sr << 1;
                        r_tx_cnt <= r_tx_cnt + 8'd1;
                    end else begin
                        r_miso <= 1'b0;
                    end
                end
            end
        end
    end

    assign SPI_MISO    = r_miso;
    assign SPI_MISO_OE = r_oe;
    assign DOUT        = r_dout;
    assign DOUT_VALID  = r_dout_valid;
    assign ABORT       = r_abort;
    assign BUSY        = (r_state == ACTIVE) || (r_state == DRAIN);

endmodule
